// File: rtl/normalizer_stream_arbiter.sv
// Round-robin arbiter that locks onto one input stream until its last beat and
// forwards the granted beats through a single output register stage.
module normalizer_stream_arbiter #(
   parameter int unsigned NUM_REQUESTERS = 4,
   parameter int unsigned NUM_ELEMENTS   = 8,
   parameter int unsigned ID_W           = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_REQUESTERS-1:0]                in_valid,
   output logic [NUM_REQUESTERS-1:0]                in_ready,
   input  logic [NUM_REQUESTERS*NUM_ELEMENTS*8-1:0] in_data,
   input  logic [NUM_REQUESTERS*NUM_ELEMENTS-1:0]   in_keep,
   input  logic [NUM_REQUESTERS-1:0]                in_last,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [NUM_ELEMENTS*8-1:0]                out_data,
   output logic [NUM_ELEMENTS-1:0]                  out_keep,
   output logic                                     out_last,
   output logic [ID_W-1:0]                          out_id
);
   localparam int unsigned DW = NUM_ELEMENTS * 8;

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e                  state_q, state_d;
   logic [ID_W-1:0]         grant_q, grant_d;
   logic [ID_W-1:0]         ptr_q, ptr_d;
   logic                    out_valid_q, out_last_q;
   logic [DW-1:0]           out_data_q;
   logic [NUM_ELEMENTS-1:0] out_keep_q;
   logic [ID_W-1:0]         out_id_q;

   logic                    can_load, accept;
   logic                    found_hi, found_lo;
   logic [ID_W-1:0]         win_hi, win_lo, win, sel;
   logic                    sel_valid, sel_last;
   logic [DW-1:0]           sel_data;
   logic [NUM_ELEMENTS-1:0] sel_keep;

   function automatic logic [ID_W-1:0] wrap_inc(logic [ID_W-1:0] x);
      return ID_W'((32'(x) + 32'd1) % NUM_REQUESTERS);
   endfunction

   assign can_load = !out_valid_q || out_ready;

   // Rotating priority: lowest valid index at or above the pointer, else lowest overall.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int r = 0; r < NUM_REQUESTERS; r++) begin
         if (in_valid[r]) begin
            if (!found_lo) begin
               win_lo   = ID_W'(r);
               found_lo = 1'b1;
            end
            if (!found_hi && (ID_W'(r) >= ptr_q)) begin
               win_hi   = ID_W'(r);
               found_hi = 1'b1;
            end
         end
      end
      win = found_hi ? win_hi : win_lo;
   end

   always_comb begin
      sel       = (state_q == StLocked) ? grant_q : win;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      in_ready  = '0;
      for (int r = 0; r < NUM_REQUESTERS; r++) begin
         if (ID_W'(r) == sel) begin
            sel_valid = in_valid[r];
            sel_last  = in_last[r];
            sel_data  = in_data[r*DW +: DW];
            sel_keep  = in_keep[r*NUM_ELEMENTS +: NUM_ELEMENTS];
            in_ready[r] = !rst && can_load && ((state_q == StLocked) || found_lo);
         end
      end
      accept = !rst && sel_valid && can_load;
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      if (accept) begin
         if (sel_last) begin
            state_d = StIdle;
            ptr_d   = wrap_inc(sel);
         end else begin
            state_d = StLocked;
            grant_d = sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_id_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         if (accept) begin
            out_valid_q <= 1'b1;
            out_last_q  <= sel_last;
            out_data_q  <= sel_data;
            out_keep_q  <= sel_keep;
            out_id_q    <= sel;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Outputs read as idle for the whole reset cycle, not only after the edge.
   assign out_valid = out_valid_q && !rst;
   assign out_last  = out_last_q && !rst;
   assign out_keep  = rst ? '0 : out_keep_q;
   assign out_id    = rst ? '0 : out_id_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_normalizer_stream_arbiter.sv
// Bench for normalizer_stream_arbiter: queue-driven requesters, a stream-owner
// reference model compared every cycle, and directed scenarios with literal results.
module tb_normalizer_stream_arbiter;
   localparam int N  = 4;
   localparam int E  = 8;
   localparam int DW = E * 8;
   localparam int IW = 2;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [E-1:0]  keep;
      logic          last;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    in_valid = '0;
   logic [N-1:0]    in_ready;
   logic [N*DW-1:0] in_data = '0;
   logic [N*E-1:0]  in_keep = '0;
   logic [N-1:0]    in_last = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [DW-1:0]   out_data;
   logic [E-1:0]    out_keep;
   logic            out_last;
   logic [IW-1:0]   out_id;

   logic [N-1:0]    en = '1;
   beat_t           q [N][$];

   int              vectors = 0;
   int              miscompares = 0;
   int              cyc = 0;

   // Reference model: which requester owns the output, the rotating start point,
   // and the beat currently sitting in the output register.
   int              m_owner = -1;
   int              m_ptr = 0;
   logic            m_valid = 1'b0;
   beat_t           m_beat = '0;
   int              m_id = 0;

   int              log_id[$];
   beat_t           log_beat[$];
   int              log_cyc[$];

   normalizer_stream_arbiter #(
      .NUM_REQUESTERS(N),
      .NUM_ELEMENTS  (E),
      .ID_W          (IW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_keep  (in_keep),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_keep (out_keep),
      .out_last (out_last),
      .out_id   (out_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick();
      if (m_owner >= 0) return m_owner;
      for (int i = 0; i < N; i++) begin
         if (in_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] v;
      int s;
      v = '0;
      if (!rst) begin
         s = pick();
         if (s >= 0) v[s] = !m_valid || out_ready;
      end
      return v;
   endfunction

   // Model update on the active edge.
   initial forever begin
      int s;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_valid = 1'b0;
         m_beat  = '0;
         m_id    = 0;
      end else begin
         s = pick();
         if (s >= 0 && in_valid[s] && (!m_valid || out_ready)) begin
            m_valid     = 1'b1;
            m_id        = s;
            m_beat.data = in_data[s*DW +: DW];
            m_beat.keep = in_keep[s*E +: E];
            m_beat.last = in_last[s];
            if (in_last[s]) begin
               m_owner = -1;
               m_ptr   = (s + 1) % N;
            end else begin
               m_owner = s;
            end
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Compare process, away from the active edge.
   initial forever begin
      @(negedge clk);
      chk("in_ready", in_ready, exp_ready());
      chk("out_valid", out_valid, m_valid && !rst);
      if (rst) begin
         chk("rst_out_last", out_last, 1'b0);
         chk("rst_out_id", out_id, '0);
         chk("rst_out_keep", out_keep, '0);
      end else if (m_valid) begin
         chk("out_data", out_data, m_beat.data);
         chk("out_keep", out_keep, m_beat.keep);
         chk("out_last", out_last, m_beat.last);
         chk("out_id", out_id, m_id);
      end
      if (!rst && out_valid && out_ready) begin
         log_id.push_back(int'(out_id));
         log_beat.push_back('{data: out_data, keep: out_keep, last: out_last});
         log_cyc.push_back(cyc);
      end
   end

   // Requester driver: present queue heads, pop on handshake.
   initial forever begin
      logic [N-1:0] acc;
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < N; r++) begin
         if (acc[r] && q[r].size() > 0) void'(q[r].pop_front());
         if (en[r] && q[r].size() > 0) begin
            in_valid[r]          = 1'b1;
            in_data[r*DW +: DW]  = q[r][0].data;
            in_keep[r*E +: E]    = q[r][0].keep;
            in_last[r]           = q[r][0].last;
         end else begin
            in_valid[r] = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_log();
      log_id.delete();
      log_beat.delete();
      log_cyc.delete();
   endtask

   task automatic do_reset();
      tick(1);
      rst       = 1'b1;
      out_ready = 1'b1;
      en        = '1;
      for (int r = 0; r < N; r++) q[r].delete();
      tick(2);
      rst = 1'b0;
      clear_log();
   endtask

   task automatic push_stream(input int r, input int len, input logic fin);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = {$urandom(), $urandom()};
         b.keep = ($urandom_range(0, 5) == 0) ? '0 : E'($urandom());
         b.last = (i == len - 1) ? fin : 1'b0;
         q[r].push_back(b);
      end
   endtask

   task automatic check_ids(input string name, input int e[$]);
      chk({name, "_count"}, log_id.size(), e.size());
      for (int i = 0; i < e.size(); i++) begin
         chk({name, "_id"}, (i < log_id.size()) ? log_id[i] : -1, e[i]);
      end
   endtask

   function automatic int q_total();
      int t = 0;
      for (int r = 0; r < N; r++) t += q[r].size();
      return t;
   endfunction

   initial begin
      int    e[$];
      beat_t b;
      logic [DW-1:0] held;
      int    k;

      // Two simultaneous 3-beat streams: no interleave, no bubble.
      do_reset();
      push_stream(0, 3, 1'b1);
      push_stream(2, 3, 1'b1);
      tick(12);
      e = '{0, 0, 0, 2, 2, 2};
      check_ids("two_streams", e);
      chk("two_streams_span", (log_cyc.size() >= 6) ? log_cyc[5] - log_cyc[0] : -1, 5);

      // Single-beat streams from everyone rotate with wrap-around.
      do_reset();
      for (int n = 0; n < 2; n++) for (int r = 0; r < N; r++) push_stream(r, 1, 1'b1);
      tick(14);
      e = '{0, 1, 2, 3, 0, 1, 2, 3};
      check_ids("round_robin", e);
      chk("round_robin_span", (log_cyc.size() >= 8) ? log_cyc[7] - log_cyc[0] : -1, 7);

      // Empty-keep last beat is forwarded as-is and moves the pointer past it.
      do_reset();
      b.data = 64'h0123_4567_89ab_cdef;
      b.keep = '0;
      b.last = 1'b1;
      q[2].push_back(b);
      tick(5);
      e = '{2};
      check_ids("keep_zero", e);
      chk("keep_zero_keep", (log_beat.size() > 0) ? log_beat[0].keep : 8'hff, 8'h00);
      chk("keep_zero_last", (log_beat.size() > 0) ? log_beat[0].last : 1'b0, 1'b1);
      en = '0;
      push_stream(0, 1, 1'b1);
      push_stream(3, 1, 1'b1);
      tick(1);
      en = '1;
      tick(6);
      e = '{2, 3, 0};
      check_ids("ptr_after_2", e);

      // Owner goes quiet mid-stream; competitor must wait.
      do_reset();
      push_stream(1, 2, 1'b0);
      push_stream(3, 1, 1'b1);
      tick(6);
      chk("gap_ready3", in_ready[3], 1'b0);
      chk("gap_out_valid", out_valid, 1'b0);
      push_stream(1, 2, 1'b1);
      tick(8);
      e = '{1, 1, 1, 1, 3};
      check_ids("locked_gap", e);

      // Output stall holds the beat and blocks all inputs.
      do_reset();
      out_ready = 1'b0;
      push_stream(0, 3, 1'b1);
      held = q[0][0].data;
      tick(7);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_id", out_id, 2'd0);
      chk("stall_data", out_data, held);
      chk("stall_ready", in_ready, 4'b0000);
      out_ready = 1'b1;
      tick(6);
      e = '{0, 0, 0};
      check_ids("stall_resume", e);
      chk("stall_first_data", (log_beat.size() > 0) ? log_beat[0].data : ~held, held);

      // Reset mid-stream drops the lock; requester 0 wins first afterwards.
      do_reset();
      en[0] = 1'b0;
      push_stream(3, 4, 1'b1);
      push_stream(0, 1, 1'b1);
      tick(3);
      rst   = 1'b1;
      en[0] = 1'b1;
      tick(1);
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_ready", in_ready, 4'b0000);
      rst = 1'b0;
      clear_log();
      tick(8);
      e = '{0, 3, 3};
      check_ids("after_rst", e);

      // Randomized traffic against the model.
      do_reset();
      repeat (3000) begin
         tick(1);
         for (int r = 0; r < N; r++) begin
            if (q[r].size() == 0 && $urandom_range(0, 2) == 0)
               push_stream(r, $urandom_range(1, 4), 1'b1);
            en[r] = ($urandom_range(0, 4) != 0);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 149) == 0);
      end
      rst       = 1'b0;
      en        = '1;
      out_ready = 1'b1;
      k = 0;
      while (q_total() > 0 && k < 200) begin
         tick(1);
         k++;
      end
      chk("drain_timeout", q_total(), 0);
      tick(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/normalizer_stream_arbiter.md
NORMALIZER_STREAM_ARBITER -- requirements
Module: normalizer_stream_arbiter

Interface
REQ-001 Parameter NUM_REQUESTERS, default 4: number of input streams sharing one data normalizer; legal range 1..16.
REQ-002 Parameter NUM_ELEMENTS, default 8: lanes per beat; each lane is 8 bits.
REQ-003 Parameter ID_W, default max(1, clog2(NUM_REQUESTERS)): width of the granted-requester tag.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  NUM_REQUESTERS  per-requester beat valid.
REQ-007 in_ready  output  NUM_REQUESTERS  per-requester beat accepted.
REQ-008 in_data  input  NUM_REQUESTERS*NUM_ELEMENTS*8  per-requester data; requester r occupies slice r.
REQ-009 in_keep  input  NUM_REQUESTERS*NUM_ELEMENTS  per-requester lane keep.
REQ-010 in_last  input  NUM_REQUESTERS  per-requester end-of-stream.
REQ-011 out_valid / out_ready  output / input  1 / 1  handshake toward the normalizer.
REQ-012 out_data / out_keep / out_last  output  NUM_ELEMENTS*8 / NUM_ELEMENTS / 1  forwarded beat.
REQ-013 out_id  output  ID_W  index of the requester that owns the current out beat.

Function
REQ-014 Two-state FSM, states IDLE and LOCKED; grant register g (ID_W bits), priority pointer p (ID_W bits).
REQ-015 Output stage is one register; can_load = !out_valid || out_ready.
REQ-016 IDLE: winner w = first r with in_valid[r]=1, searching p, p+1, ... modulo NUM_REQUESTERS (wrap past NUM_REQUESTERS-1 to 0).
REQ-017 IDLE: in_ready[w] = can_load; all other in_ready = 0; no valid requester -> all in_ready = 0, state unchanged.
REQ-018 LOCKED: in_ready[g] = can_load; all other in_ready = 0 regardless of their in_valid.
REQ-019 Accepted beat (in_valid[x] && in_ready[x]): out_data/out_keep/out_last <= slice x; out_id <= x; out_valid <= 1; latency exactly 1 cycle.
REQ-020 No accept and out_ready=1: out_valid <= 0; out_valid && !out_ready: all out_* held stable.
REQ-021 IDLE accept with in_last=0 -> LOCKED, g <= w; with in_last=1 (single-beat stream) -> stay IDLE, p <= (w+1) mod NUM_REQUESTERS.
REQ-022 LOCKED accept with in_last=1 -> IDLE, p <= (g+1) mod NUM_REQUESTERS; in_last=0 -> stay LOCKED.
REQ-023 Stream switch is bubble-free: IDLE arbitrates in the cycle after a last beat is accepted; back-to-back streams sustain 1 beat/cycle while out_ready=1.
REQ-024 A stream is never interleaved: between a requester's first accepted beat and its last accepted beat, no other requester's beat is accepted.
REQ-025 Beats with in_keep=0 are forwarded unchanged (including in_last); no lane modification, no drop.
REQ-026 in_valid deasserting mid-stream while LOCKED: remain LOCKED, emit nothing, wait for g.
REQ-027 NUM_REQUESTERS=1: behaves as a one-stage register slice, out_id = 0.

Reset
REQ-028 While rst=1: out_valid=0, out_last=0, out_id=0, out_keep=0, all in_ready=0, state=IDLE, p=0, g=0; out_data don't-care.
REQ-029 rst asserted mid-stream discards the in-flight beat and lock; the first cycle after rst deasserts arbitrates from requester 0.

Verification
REQ-030 N=4, requesters 0 and 2 each send 3-beat stream simultaneously, out_ready=1 -> out_id sequence 0,0,0,2,2,2, out_valid continuous 6 cycles, first beat 1 cycle after first accept.
REQ-031 All 4 requesters continuously offer 1-beat streams (in_last=1) -> out_id 0,1,2,3,0,1 (round-robin wrap).
REQ-032 Requester 1 locked, sends 2 of 4 beats, then in_valid[1]=0 for 3 cycles while requester 3 valid -> in_ready[3]=0 throughout, out_valid=0 during gap, then requester 1 completes, then requester 3 granted.
REQ-033 out_ready=0 for 5 cycles with out_valid=1 -> out_data/keep/last/id stable, all in_ready=0; out_ready=1 resumes with no lost or duplicated beat.
REQ-034 Beat with in_keep=0 and in_last=1 from requester 2 -> forwarded with out_keep=0, out_last=1, out_id=2; arbiter returns to IDLE, p=3.
REQ-035 rst pulsed for 1 cycle during requester 3's beat 2 of 4 -> next cycle out_valid=0; afterward requester 0 (if valid) wins before requester 3.
